// File: rtl/park_pkg.sv
// Types shared by the car-park gate controllers: the gate FSM state encoding
// and a helper that tells whether a state holds the barrier open.
package park_pkg;

  localparam int STATE_W = 3;

  typedef enum logic [STATE_W-1:0] {
    IDLE       = 3'd0,
    WAIT_PASS  = 3'd1,
    ENTER_OPEN = 3'd2,
    EXIT_OPEN  = 3'd3,
    LOCKOUT    = 3'd4
  } state_t;

  function automatic logic is_open(input state_t s);
    return (s == ENTER_OPEN) || (s == EXIT_OPEN);
  endfunction

endpackage

// File: rtl/park_occupancy_counter.sv
// Saturating up/down count of occupied spaces, with full and empty flags
// decoded from the registered count.
module park_occupancy_counter #(
  parameter  int CAPACITY = 8,
  localparam int CNT_W    = $clog2(CAPACITY + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             i_inc,
  input  logic             i_dec,
  output logic [CNT_W-1:0] o_count,
  output logic             o_full,
  output logic             o_empty
);

  localparam logic [CNT_W-1:0] CAP_V = CNT_W'(CAPACITY);
  localparam logic [CNT_W-1:0] ONE_V = CNT_W'(1);

  logic [CNT_W-1:0] r_count;
  logic             w_full;
  logic             w_empty;

  assign w_full  = (r_count == CAP_V);
  assign w_empty = (r_count == '0);

  always_ff @(posedge clk) begin
    if (rst) begin
      r_count <= '0;
    end else if (i_inc && !i_dec && !w_full) begin
      r_count <= r_count + ONE_V;
    end else if (i_dec && !i_inc && !w_empty) begin
      r_count <= r_count - ONE_V;
    end
  end

  assign o_count = r_count;
  assign o_full  = w_full;
  assign o_empty = w_empty;

endmodule

// File: rtl/park_gate_controller.sv
// Single-barrier car park controller: keypad entry with retry lockout,
// exit on request, auto-close of the open gate, and occupancy tracking.
//
//   state      | meaning
//   IDLE       | gate closed, waiting for an entry or exit request
//   WAIT_PASS  | car at the keypad, waiting for a code strobe
//   ENTER_OPEN | gate open for an entering car
//   EXIT_OPEN  | gate open for a leaving car
//   LOCKOUT    | too many wrong codes, requests ignored, alarm on
module park_gate_controller
  import park_pkg::*;
#(
  parameter  int              PASS_W         = 5,
  parameter  logic [PASS_W-1:0] PASS_CODE    = 5'b10101,
  parameter  int              CAPACITY       = 8,
  parameter  int              MAX_TRIES      = 3,
  parameter  int              LOCKOUT_CYCLES = 16,
  parameter  int              OPEN_TIMEOUT   = 32,
  localparam int              CNT_W          = $clog2(CAPACITY + 1)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              entrance_sensor,
  input  logic              exit_sensor,
  input  logic              gate_pass_sensor,
  input  logic [PASS_W-1:0] pass,
  input  logic              pass_valid,
  output logic              red_led,
  output logic              green_led,
  output logic              lock,
  output logic              full,
  output logic              alarm,
  output logic [CNT_W-1:0]  occupancy
);

  localparam int TMR_MAX = (OPEN_TIMEOUT > LOCKOUT_CYCLES) ? OPEN_TIMEOUT : LOCKOUT_CYCLES;
  localparam int TMR_W   = $clog2(TMR_MAX + 1);
  localparam int TRY_W   = $clog2(MAX_TRIES + 1);

  localparam logic [TMR_W-1:0] OT_LAST  = TMR_W'(OPEN_TIMEOUT - 1);
  localparam logic [TMR_W-1:0] LK_LAST  = TMR_W'(LOCKOUT_CYCLES - 1);
  localparam logic [TRY_W-1:0] TRY_LAST = TRY_W'(MAX_TRIES - 1);

  state_t           r_state;
  state_t           w_next;
  logic [TMR_W-1:0] r_timer;
  logic [TRY_W-1:0] r_tries;
  logic             w_inc;
  logic             w_dec;
  logic             w_tries_clr;
  logic             w_tries_inc;
  logic             w_full;
  logic             w_empty;
  logic             w_open;

  park_occupancy_counter #(
    .CAPACITY (CAPACITY)
  ) u_occ (
    .clk     (clk),
    .rst     (rst),
    .i_inc   (w_inc),
    .i_dec   (w_dec),
    .o_count (occupancy),
    .o_full  (w_full),
    .o_empty (w_empty)
  );

  always_comb begin
    w_next      = r_state;
    w_inc       = 1'b0;
    w_dec       = 1'b0;
    w_tries_clr = 1'b0;
    w_tries_inc = 1'b0;
    case (r_state)
      IDLE: begin
        if (exit_sensor && !w_empty) begin
          w_next = EXIT_OPEN;
        end else if (entrance_sensor && !w_full) begin
          w_next      = WAIT_PASS;
          w_tries_clr = 1'b1;
        end
      end
      WAIT_PASS: begin
        // a code strobe wins over the car backing away in the same cycle
        if (pass_valid) begin
          if (pass == PASS_CODE) begin
            w_next = ENTER_OPEN;
          end else begin
            w_tries_inc = 1'b1;
            if (r_tries == TRY_LAST) w_next = LOCKOUT;
          end
        end else if (!entrance_sensor) begin
          w_next = IDLE;
        end
      end
      ENTER_OPEN: begin
        if (gate_pass_sensor) begin
          w_inc  = 1'b1;
          w_next = IDLE;
        end else if (r_timer == OT_LAST) begin
          w_next = IDLE;
        end
      end
      EXIT_OPEN: begin
        if (gate_pass_sensor) begin
          w_dec  = 1'b1;
          w_next = IDLE;
        end else if (r_timer == OT_LAST) begin
          w_next = IDLE;
        end
      end
      LOCKOUT: begin
        if (r_timer == LK_LAST) begin
          w_next      = IDLE;
          w_tries_clr = 1'b1;
        end
      end
      default: w_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= IDLE;
      r_timer <= '0;
      r_tries <= '0;
    end else begin
      r_state <= w_next;
      if (w_next != r_state) begin
        r_timer <= '0;
      end else if (is_open(r_state) || (r_state == LOCKOUT)) begin
        r_timer <= r_timer + TMR_W'(1);
      end
      if (w_tries_clr) begin
        r_tries <= '0;
      end else if (w_tries_inc) begin
        r_tries <= r_tries + TRY_W'(1);
      end
    end
  end

  assign w_open    = is_open(r_state);
  assign green_led = w_open;
  assign red_led   = !w_open;
  assign lock      = !w_open;
  assign alarm     = (r_state == LOCKOUT);
  assign full      = w_full;

endmodule

// File: tb/tb_park_gate_controller.sv
// Bench for park_gate_controller: directed scenarios plus random traffic,
// all checked against a behavioural model of the gate rules.
module tb_park_gate_controller;

  localparam int         CAP  = 8;
  localparam int         MAXT = 3;
  localparam int         LCK  = 16;
  localparam int         OT   = 32;
  localparam logic [4:0] CODE = 5'b10101;
  localparam logic [8:0] RST_VEC = 9'b1_0_1_0_0_0000;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       entrance_sensor = 1'b0;
  logic       exit_sensor = 1'b0;
  logic       gate_pass_sensor = 1'b0;
  logic [4:0] pass = 5'd0;
  logic       pass_valid = 1'b0;
  logic       red_led, green_led, lock, full, alarm;
  logic [3:0] occupancy;
  logic [8:0] dut_vec;

  int n_cmp = 0;
  int n_err = 0;

  // model: mode 0 idle, 1 waiting for code, 2 open for entry, 3 open for exit, 4 locked out
  int m_mode = 0;
  int m_occ = 0;
  int m_tries = 0;
  int m_t = 0;

  park_gate_controller dut (
    .clk              (clk),
    .rst              (rst),
    .entrance_sensor  (entrance_sensor),
    .exit_sensor      (exit_sensor),
    .gate_pass_sensor (gate_pass_sensor),
    .pass             (pass),
    .pass_valid       (pass_valid),
    .red_led          (red_led),
    .green_led        (green_led),
    .lock             (lock),
    .full             (full),
    .alarm            (alarm),
    .occupancy        (occupancy)
  );

  always #5 clk = ~clk;

  assign dut_vec = {red_led, green_led, lock, full, alarm, occupancy};

  function automatic logic [8:0] exp_vec();
    logic g;
    g = (m_mode == 2) || (m_mode == 3);
    return {!g, g, !g, (m_occ == CAP), (m_mode == 4), 4'(m_occ)};
  endfunction

  task automatic step(input logic r, input logic e, input logic x, input logic g,
                      input logic v, input logic [4:0] c);
    int nm;
    rst = r; entrance_sensor = e; exit_sensor = x; gate_pass_sensor = g;
    pass_valid = v; pass = c;
    @(posedge clk);
    if (r) begin
      m_mode = 0; m_occ = 0; m_tries = 0; m_t = 0;
    end else begin
      nm = m_mode;
      case (m_mode)
        0: if (x && m_occ > 0) nm = 3;
           else if (e && m_occ < CAP) begin nm = 1; m_tries = 0; end
        1: if (v) begin
             if (c == CODE) nm = 2;
             else begin m_tries++; if (m_tries == MAXT) nm = 4; end
           end else if (!e) nm = 0;
        2, 3: if (g) begin m_occ += (m_mode == 2) ? 1 : -1; nm = 0; end
              else if (m_t + 1 == OT) nm = 0;
        4: if (m_t + 1 == LCK) begin nm = 0; m_tries = 0; end
        default: nm = 0;
      endcase
      if (nm != m_mode) m_t = 0;
      else if (m_mode >= 2) m_t++;
      m_mode = nm;
    end
    #1;
  endtask

  task automatic idle();
    step(0, 0, 0, 0, 0, 5'd0);
  endtask

  task automatic do_entry();
    step(0, 1, 0, 0, 0, 5'd0);
    step(0, 1, 0, 0, 1, CODE);
    step(0, 0, 0, 1, 0, 5'd0);
  endtask

  task automatic do_exit();
    step(0, 0, 1, 0, 0, 5'd0);
    step(0, 0, 0, 1, 0, 5'd0);
  endtask

  task automatic test_reset();
    step(1, 0, 0, 0, 0, 5'd0);
    n_cmp++;
    if (dut_vec !== RST_VEC) begin
      n_err++; $display("FAIL reset_state: got %b want %b", dut_vec, RST_VEC);
    end
    idle();
    n_cmp++;
    if (dut_vec !== exp_vec()) begin
      n_err++; $display("FAIL reset_idle: got %b want %b", dut_vec, exp_vec());
    end
  endtask

  task automatic test_basic_entry();
    step(0, 1, 0, 0, 0, 5'd0);
    n_cmp++;
    if (dut_vec !== exp_vec()) begin
      n_err++; $display("FAIL entry_wait: got %b want %b", dut_vec, exp_vec());
    end
    step(0, 1, 0, 0, 1, CODE);
    n_cmp++;
    if ({green_led, lock} !== 2'b10) begin
      n_err++; $display("FAIL entry_open: got green/lock %b want 10", {green_led, lock});
    end
    step(0, 0, 0, 1, 0, 5'd0);
    n_cmp++;
    if ({lock, occupancy} !== {1'b1, 4'd1}) begin
      n_err++; $display("FAIL entry_pass: got lock/occ %b want 1_0001", {lock, occupancy});
    end
  endtask

  task automatic test_fill();
    repeat (CAP - 1) do_entry();
    n_cmp++;
    if ({full, occupancy} !== {1'b1, 4'd8}) begin
      n_err++; $display("FAIL fill_full: got full/occ %b want 1_1000", {full, occupancy});
    end
    for (int i = 0; i < 3; i++) begin
      step(0, 1, 0, 0, 1, CODE);
      n_cmp++;
      if ({red_led, green_led, occupancy} !== {2'b10, 4'd8} || dut_vec !== exp_vec()) begin
        n_err++; $display("FAIL fill_refuse: got %b want %b", dut_vec, exp_vec());
      end
    end
    do_exit();
    n_cmp++;
    if (occupancy !== 4'd7) begin
      n_err++; $display("FAIL fill_exit: got occ %0d want 7", occupancy);
    end
  endtask

  task automatic test_lockout();
    int cnt;
    step(0, 1, 0, 0, 0, 5'd0);
    repeat (MAXT) step(0, 1, 0, 0, 1, 5'b00000);
    n_cmp++;
    if (alarm !== 1'b1) begin
      n_err++; $display("FAIL lockout_enter: got alarm %b want 1", alarm);
    end
    cnt = 1;
    for (int i = 0; i < 40; i++) begin
      step(0, 1, 1, 0, 0, 5'd0);
      n_cmp++;
      if (dut_vec !== exp_vec()) begin
        n_err++; $display("FAIL lockout_hold: got %b want %b", dut_vec, exp_vec());
      end
      if (alarm) cnt++;
      else break;
    end
    n_cmp++;
    if (cnt !== LCK) begin
      n_err++; $display("FAIL lockout_len: got %0d cycles want %0d", cnt, LCK);
    end
    n_cmp++;
    if ({alarm, red_led, occupancy} !== {2'b01, 4'd7}) begin
      n_err++; $display("FAIL lockout_exit: got alarm/red/occ %b want 01_0111",
                        {alarm, red_led, occupancy});
    end
    step(0, 1, 0, 0, 0, 5'd0);
    step(0, 1, 0, 0, 1, CODE);
    n_cmp++;
    if (green_led !== 1'b1) begin
      n_err++; $display("FAIL lockout_recover: got green %b want 1", green_led);
    end
    step(0, 0, 0, 1, 0, 5'd0);
    do_exit();
    do_exit();
  endtask

  task automatic test_timeout();
    int cnt;
    int occ0;
    occ0 = m_occ;
    step(0, 1, 0, 0, 0, 5'd0);
    step(0, 1, 0, 0, 1, CODE);
    cnt = green_led ? 1 : 0;
    for (int i = 0; i < 40; i++) begin
      idle();
      if (green_led) cnt++;
      else break;
    end
    n_cmp++;
    if (cnt !== OT) begin
      n_err++; $display("FAIL timeout_len: got %0d open cycles want %0d", cnt, OT);
    end
    n_cmp++;
    if ({lock, occupancy} !== {1'b1, 4'(occ0)}) begin
      n_err++; $display("FAIL timeout_occ: got lock/occ %b want %b", {lock, occupancy},
                        {1'b1, 4'(occ0)});
    end
    step(0, 1, 0, 0, 0, 5'd0);
    step(0, 1, 0, 0, 1, CODE);
    repeat (OT - 1) idle();
    n_cmp++;
    if (green_led !== 1'b1) begin
      n_err++; $display("FAIL timeout_last_cycle: got green %b want 1", green_led);
    end
    step(0, 0, 0, 1, 0, 5'd0);
    n_cmp++;
    if ({green_led, occupancy} !== {1'b0, 4'(occ0 + 1)}) begin
      n_err++; $display("FAIL timeout_pass: got green/occ %b want %b", {green_led, occupancy},
                        {1'b0, 4'(occ0 + 1)});
    end
  endtask

  task automatic test_exit_priority();
    for (int i = 0; i < 10 && m_occ > 2; i++) do_exit();
    for (int i = 0; i < 10 && m_occ < 2; i++) do_entry();
    step(0, 1, 1, 0, 0, 5'd0);
    n_cmp++;
    if (green_led !== 1'b1) begin
      n_err++; $display("FAIL prio_open: got green %b want 1", green_led);
    end
    step(0, 0, 0, 1, 0, 5'd0);
    n_cmp++;
    if (occupancy !== 4'd1) begin
      n_err++; $display("FAIL prio_exit: got occ %0d want 1", occupancy);
    end
    do_exit();
    for (int i = 0; i < 3; i++) begin
      step(0, 0, 1, i == 2, 0, 5'd0);
      n_cmp++;
      if ({red_led, occupancy} !== {1'b1, 4'd0}) begin
        n_err++; $display("FAIL empty_exit: got red/occ %b want 1_0000", {red_led, occupancy});
      end
    end
  endtask

  task automatic test_reset_mid();
    do_entry();
    step(0, 1, 0, 0, 0, 5'd0);
    step(0, 1, 0, 0, 1, CODE);
    step(1, 0, 0, 0, 0, 5'd0);
    n_cmp++;
    if (dut_vec !== RST_VEC) begin
      n_err++; $display("FAIL reset_open: got %b want %b", dut_vec, RST_VEC);
    end
    step(0, 1, 0, 0, 0, 5'd0);
    repeat (MAXT) step(0, 1, 0, 0, 1, 5'b01010);
    step(1, 0, 0, 0, 0, 5'd0);
    n_cmp++;
    if (dut_vec !== RST_VEC) begin
      n_err++; $display("FAIL reset_lockout: got %b want %b", dut_vec, RST_VEC);
    end
    idle();
  endtask

  task automatic test_random();
    logic r, e, x, g, v;
    logic [4:0] c;
    for (int i = 0; i < 3000; i++) begin
      r = ($urandom_range(199) == 0);
      e = $urandom_range(1) == 1;
      x = ($urandom_range(3) == 0);
      g = ($urandom_range(5) == 0);
      v = ($urandom_range(3) == 0);
      c = ($urandom_range(1) == 1) ? CODE : 5'($urandom_range(31));
      step(r, e, x, g, v, c);
      n_cmp++;
      if (dut_vec !== exp_vec()) begin
        n_err++; $display("FAIL random[%0d]: got %b want %b", i, dut_vec, exp_vec());
      end
    end
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_basic_entry();
    test_fill();
    test_lockout();
    test_timeout();
    test_exit_priority();
    test_reset_mid();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
